// File: rtl/inc_arbiter.sv
`default_nettype none
//============================================================================
// Module : inc_arbiter
// Turns button presses and holds into one-hot increment grants with
// auto-repeat and round-robin arbitration. Optional macro ADVCNT_ACCEL_EN
// enables accelerated auto-repeat after ACCEL_AFTER repeats.
// Revision: 1.0 - initial release
//============================================================================
module inc_arbiter #(
    parameter int DIGITS       = 3,
    parameter int TMR_W        = 8,
    parameter int REPEAT_DELAY = 8,
    parameter int REPEAT_RATE  = 2,
    parameter int ACCEL_AFTER  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick,
    input  logic [DIGITS-1:0] btn_level,
    input  logic              inc_ready,
    output logic [DIGITS-1:0] inc_grant,
    output logic              inc_valid,
    output logic [7:0]        merged_cnt
);

    localparam int                c_PTR_W      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [TMR_W-1:0]  c_DELAY_LAST = TMR_W'(REPEAT_DELAY - 1);
    localparam logic [TMR_W-1:0]  c_RATE_LAST  = TMR_W'(REPEAT_RATE - 1);
`ifdef ADVCNT_ACCEL_EN
    localparam int                c_FAST_RATE  = (REPEAT_RATE / 2 > 1) ? (REPEAT_RATE / 2) : 1;
    localparam logic [TMR_W-1:0]  c_FAST_LAST  = TMR_W'(c_FAST_RATE - 1);
    localparam int                c_ACC_W      = (ACCEL_AFTER > 0) ? $clog2(ACCEL_AFTER + 1) : 1;
    localparam logic [c_ACC_W-1:0] c_ACC_MAX   = c_ACC_W'(ACCEL_AFTER);
`endif

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_HOLD_WAIT = 2'd1,
        S_REPEAT    = 2'd2
    } state_t;

    generate
        if (REPEAT_DELAY < 1 || REPEAT_RATE < 1 || ACCEL_AFTER < 1 ||
            REPEAT_DELAY >= (2 ** TMR_W) || REPEAT_RATE >= (2 ** TMR_W)) begin : g_param_check
            $error("inc_arbiter: repeat parameters out of range");
        end
    endgenerate

    logic [DIGITS-1:0]  r_btn;
    logic [DIGITS-1:0]  r_btn_prev;
    logic [DIGITS-1:0]  r_pending;
    logic [c_PTR_W-1:0] r_rr;

    logic [DIGITS-1:0]  w_rise;
    logic [DIGITS-1:0]  w_set;
    logic [DIGITS-1:0]  w_clr;
    logic [DIGITS-1:0]  w_merge;
    logic [c_PTR_W-1:0] w_sel_idx;
    logic [c_PTR_W-1:0] w_rr_next;
    logic               w_found;
    logic               w_take;
    int                 w_idx;
    logic [15:0]        w_merge_num;
    logic [15:0]        w_merge_sum;
    logic [7:0]         w_merged_next;

    assign w_rise = r_btn & ~r_btn_prev;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            state_t           r_state;
            logic [TMR_W-1:0] r_timer;
            logic [TMR_W-1:0] w_rate_last;
            logic             w_fire_hold;
            logic             w_fire_rep;

            assign w_fire_hold = (r_state == S_HOLD_WAIT) && r_btn[gi] && tick &&
                                 (r_timer == c_DELAY_LAST);
            assign w_fire_rep  = (r_state == S_REPEAT) && r_btn[gi] && tick &&
                                 (r_timer == w_rate_last);
            assign w_set[gi]   = ((r_state == S_IDLE) && w_rise[gi]) || w_fire_hold || w_fire_rep;

`ifdef ADVCNT_ACCEL_EN
            logic [c_ACC_W-1:0] r_rep_cnt;

            // Counts repeats issued from REPEAT only; saturates once the fast rate engages.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rep_cnt <= '0;
                end else if (!r_btn[gi] || (r_state == S_IDLE)) begin
                    r_rep_cnt <= '0;
                end else if (w_fire_rep && (r_rep_cnt != c_ACC_MAX)) begin
                    r_rep_cnt <= r_rep_cnt + c_ACC_W'(1);
                end
            end

            assign w_rate_last = (r_rep_cnt == c_ACC_MAX) ? c_FAST_LAST : c_RATE_LAST;
`else
            assign w_rate_last = c_RATE_LAST;
`endif

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_state <= S_IDLE;
                    r_timer <= '0;
                end else if (!r_btn[gi]) begin
                    r_state <= S_IDLE;
                    r_timer <= '0;
                end else begin
                    case (r_state)
                        S_IDLE: begin
                            if (w_rise[gi]) begin
                                r_state <= S_HOLD_WAIT;
                                r_timer <= '0;
                            end
                        end
                        S_HOLD_WAIT: begin
                            if (tick) begin
                                if (r_timer == c_DELAY_LAST) begin
                                    r_state <= S_REPEAT;
                                    r_timer <= '0;
                                end else begin
                                    r_timer <= r_timer + TMR_W'(1);
                                end
                            end
                        end
                        S_REPEAT: begin
                            if (tick) begin
                                if (r_timer == w_rate_last) begin
                                    r_timer <= '0;
                                end else begin
                                    r_timer <= r_timer + TMR_W'(1);
                                end
                            end
                        end
                        default: begin
                            r_state <= S_IDLE;
                            r_timer <= '0;
                        end
                    endcase
                end
            end
        end
    endgenerate

    // First pending digit at or after the round-robin pointer, wrapping.
    always_comb begin
        w_found   = 1'b0;
        w_sel_idx = '0;
        w_idx     = 0;
        for (int k = 0; k < DIGITS; k++) begin
            w_idx = int'(r_rr) + k;
            if (w_idx >= DIGITS) begin
                w_idx = w_idx - DIGITS;
            end
            if (!w_found && r_pending[c_PTR_W'(w_idx)]) begin
                w_found   = 1'b1;
                w_sel_idx = c_PTR_W'(w_idx);
            end
        end
    end

    always_comb begin
        w_take = w_found && inc_ready;
        w_clr  = '0;
        for (int j = 0; j < DIGITS; j++) begin
            w_clr[j] = w_take && (w_sel_idx == c_PTR_W'(j));
        end
        w_rr_next = (w_sel_idx == c_PTR_W'(DIGITS - 1)) ? '0 : (w_sel_idx + c_PTR_W'(1));
    end

    // A set that coincides with its own grant re-arms pending and is not a merge.
    always_comb begin
        w_merge     = w_set & r_pending & ~w_clr;
        w_merge_num = '0;
        for (int j = 0; j < DIGITS; j++) begin
            w_merge_num = w_merge_num + 16'(w_merge[j]);
        end
        w_merge_sum   = {8'd0, merged_cnt} + w_merge_num;
        w_merged_next = (w_merge_sum > 16'd255) ? 8'hFF : w_merge_sum[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btn      <= '0;
            r_btn_prev <= '0;
            r_pending  <= '0;
            r_rr       <= '0;
            inc_grant  <= '0;
            inc_valid  <= 1'b0;
            merged_cnt <= '0;
        end else begin
            r_btn      <= btn_level;
            r_btn_prev <= r_btn;
            r_pending  <= (r_pending & ~w_clr) | w_set;
            if (w_take) begin
                r_rr <= w_rr_next;
            end
            inc_grant  <= w_clr;
            inc_valid  <= w_take;
            merged_cnt <= w_merged_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inc_arbiter.sv
`default_nettype none
//============================================================================
// Module : tb_inc_arbiter
// Randomised and directed bench for inc_arbiter against a behavioural model.
// Revision: 1.0 - initial release
//============================================================================
module tb_inc_arbiter;

    localparam int DIGITS = 3;
    localparam int TMR_W  = 8;
    localparam int DELAY  = 4;
    localparam int RATE   = 2;
    localparam int ACC    = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              tick;
    logic [DIGITS-1:0] btn_level;
    logic              inc_ready;
    logic [DIGITS-1:0] inc_grant;
    logic              inc_valid;
    logic [7:0]        merged_cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    inc_arbiter #(
        .DIGITS      (DIGITS),
        .TMR_W       (TMR_W),
        .REPEAT_DELAY(DELAY),
        .REPEAT_RATE (RATE),
        .ACCEL_AFTER (ACC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .btn_level  (btn_level),
        .inc_ready  (inc_ready),
        .inc_grant  (inc_grant),
        .inc_valid  (inc_valid),
        .merged_cnt (merged_cnt)
    );

    always #5 clk = ~clk;

    // Model: a press is scheduled to fire at hold tick DELAY, then every gap ticks.
    bit [DIGITS-1:0]   m_btn_q, m_prev, m_act, m_pend;
    int                m_ticks[DIGITS];
    int                m_target[DIGITS];
    int                m_fires[DIGITS];
    int                m_rr;
    logic [DIGITS-1:0] exp_grant;
    logic              exp_valid;
    int                exp_merged;
    logic [DIGITS-1:0] obs[$];
    logic [DIGITS-1:0] rb;

    function automatic int gap(input int fires);
`ifdef ADVCNT_ACCEL_EN
        if (fires - 1 >= ACC) return (RATE / 2 > 1) ? RATE / 2 : 1;
`endif
        return RATE;
    endfunction

    task automatic model_reset();
        m_btn_q = '0; m_prev = '0; m_act = '0; m_pend = '0; m_rr = 0;
        for (int i = 0; i < DIGITS; i++) begin
            m_ticks[i] = 0; m_target[i] = 0; m_fires[i] = 0;
        end
        exp_grant = '0; exp_valid = 1'b0; exp_merged = 0;
    endtask

    task automatic model_step();
        bit [DIGITS-1:0] set_v;
        bit [DIGITS-1:0] clr_v;
        int sel;
        set_v = '0; clr_v = '0; sel = -1;
        for (int i = 0; i < DIGITS; i++) begin
            if (m_btn_q[i] && !m_prev[i]) begin
                set_v[i] = 1'b1; m_act[i] = 1'b1;
                m_ticks[i] = 0; m_target[i] = DELAY; m_fires[i] = 0;
            end else if (!m_btn_q[i]) begin
                m_act[i] = 1'b0;
            end else if (m_act[i] && tick) begin
                m_ticks[i]++;
                if (m_ticks[i] == m_target[i]) begin
                    set_v[i] = 1'b1;
                    m_fires[i]++;
                    m_target[i] += gap(m_fires[i]);
                end
            end
        end
        exp_grant = '0; exp_valid = 1'b0;
        if (inc_ready) begin
            for (int k = 0; k < DIGITS; k++) begin
                int idx;
                idx = (m_rr + k) % DIGITS;
                if (sel < 0 && m_pend[idx]) sel = idx;
            end
        end
        if (sel >= 0) begin
            clr_v[sel] = 1'b1; exp_grant[sel] = 1'b1; exp_valid = 1'b1;
            m_rr = (sel + 1) % DIGITS;
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (set_v[i] && m_pend[i] && !clr_v[i] && exp_merged < 255) exp_merged++;
        end
        m_pend  = (m_pend & ~clr_v) | set_v;
        m_prev  = m_btn_q;
        m_btn_q = btn_level;
    endtask

    task automatic check(input string name, input integer act, input integer req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // One clock: apply inputs, advance the model, compare on the falling edge.
    task automatic cycle(input logic [DIGITS-1:0] b, input logic t, input logic r);
        btn_level = b; tick = t; inc_ready = r;
        model_step();
        @(negedge clk);
        cyc++;
        total++;
        if (inc_grant !== exp_grant || inc_valid !== exp_valid ||
            merged_cnt !== exp_merged[7:0]) begin
            bad++;
            $display("FAIL cycle %0d: grant=%b want %b valid=%b want %b merged=%0d want %0d",
                     cyc, inc_grant, exp_grant, inc_valid, exp_valid, merged_cnt, exp_merged);
        end
        obs.push_back(inc_grant);
    endtask

    function automatic int count_nz();
        int n = 0;
        foreach (obs[i]) if (obs[i] != '0) n++;
        return n;
    endfunction

    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        check("async reset grant", inc_grant, 0);
        check("async reset valid", inc_valid, 0);
        check("async reset merged", merged_cnt, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; btn_level = '1; tick = 1'b0; inc_ready = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset grant", inc_grant, 0);
        check("reset valid", inc_valid, 0);
        check("reset merged", merged_cnt, 0);
        rst_n = 1'b1;

        // All buttons held through reset: round-robin 001, 010, 100.
        obs.delete();
        repeat (6) cycle(3'b111, 1'b0, 1'b1);
        repeat (4) cycle(3'b000, 1'b0, 1'b1);
        check("contention first", obs[2], 1);
        check("contention second", obs[3], 2);
        check("contention third", obs[4], 4);
        check("contention count", count_nz(), 3);

        // Short press of digit 1 held for two ticks.
        obs.delete();
        for (int c = 0; c < 6; c++) cycle(3'b010, (c == 2 || c == 4), 1'b1);
        repeat (4) cycle(3'b000, 1'b0, 1'b1);
        check("single press slot", obs[2], 2);
        check("single press count", count_nz(), 1);

        // Hold digit 0 for ten ticks: initial grant plus repeats at ticks 4,6,8,10.
        obs.delete();
        for (int c = 0; c < 22; c++) cycle(3'b001, (c >= 2 && c % 2 == 0), 1'b1);
        repeat (4) cycle(3'b000, 1'b0, 1'b1);
        check("hold repeat count", count_nz(), 5);

        // Backpressure on digit 2 while repeats keep arriving.
        obs.delete();
        for (int c = 0; c < 22; c++) cycle(3'b100, (c >= 2), 1'b0);
        repeat (2) cycle(3'b000, 1'b0, 1'b0);
        check("backpressure grants", count_nz(), 0);
`ifdef ADVCNT_ACCEL_EN
        check("backpressure merged", merged_cnt, 13);
`else
        check("backpressure merged", merged_cnt, 9);
`endif
        obs.delete();
        repeat (5) cycle(3'b000, 1'b0, 1'b1);
        check("backpressure release count", count_nz(), 1);
        check("backpressure release grant", obs[0], 4);

        // Saturate the merge counter.
        repeat (250) cycle(3'b111, 1'b1, 1'b0);
        check("merged saturation", merged_cnt, 255);
        repeat (4) cycle(3'b000, 1'b0, 1'b1);

        // Random traffic with one asynchronous reset mid-run.
        rb = '0;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < DIGITS; i++) begin
                if ($urandom_range(0, 9) == 0) rb[i] = ~rb[i];
            end
            if (n == 1500) async_reset();
            cycle(rb, ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
